// File: rtl/scgra_io_pkg.sv
// Shared types and widths for the SCGRA I/O controller.
// Holds the FSM encoding and the run-parameter widths.
package scgra_io_pkg;

   localparam int RUN_LEN_W   = 16;
   localparam int STORE_DLY_W = 8;
   // One extra bit so Store_Delay + Run_Len - 1 never overflows the window counter.
   localparam int WIN_W       = RUN_LEN_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   function automatic logic [WIN_W-1:0] win_end(input logic [RUN_LEN_W-1:0]   run_len,
                                                input logic [STORE_DLY_W-1:0] store_delay);
      return WIN_W'(run_len) + WIN_W'(store_delay);
   endfunction

endpackage

// File: rtl/scgra_io_ctrl_if.sv
// Signal bundle between the I/O controller and its buffers / IO PE.
// Start is a level request honoured only while the controller is idle; In_Buf_Data
// is valid the cycle after In_Buf_Rd; Out_Buf_Wr is a write strobe with no back-pressure.
interface scgra_io_ctrl_if
   import scgra_io_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int BUF_AWIDTH = 10
);

   logic                   Start;
   logic [RUN_LEN_W-1:0]   Run_Len;
   logic [STORE_DLY_W-1:0] Store_Delay;
   logic                   Ctrl_Busy;
   logic                   Done;
   logic                   PE_Array_Busy;
   logic                   In_Buf_Rd;
   logic [BUF_AWIDTH-1:0]  In_Buf_Addr;
   logic [DWIDTH-1:0]      In_Buf_Data;
   logic [DWIDTH-1:0]      PE_Load;
   logic [DWIDTH-1:0]      PE_Store;
   logic                   Out_Buf_Wr;
   logic [BUF_AWIDTH-1:0]  Out_Buf_Addr;
   logic [DWIDTH-1:0]      Out_Buf_Data;

   modport master (
      input  Start, Run_Len, Store_Delay, In_Buf_Data, PE_Store,
      output Ctrl_Busy, Done, PE_Array_Busy, In_Buf_Rd, In_Buf_Addr, PE_Load,
             Out_Buf_Wr, Out_Buf_Addr, Out_Buf_Data
   );

   modport slave (
      output Start, Run_Len, Store_Delay, In_Buf_Data, PE_Store,
      input  Ctrl_Busy, Done, PE_Array_Busy, In_Buf_Rd, In_Buf_Addr, PE_Load,
             Out_Buf_Wr, Out_Buf_Addr, Out_Buf_Data
   );

endinterface

// File: rtl/scgra_io_ctrl.sv
// I/O controller for the SCGRA: streams the input buffer into the IO PE during RUN and
// captures a delayed window of PE_Store words into the output buffer. All outputs registered.
module scgra_io_ctrl
   import scgra_io_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int BUF_AWIDTH = 10
)(
   input  logic                   Clk,
   input  logic                   Resetn,
   input  logic                   Start,
   input  logic [RUN_LEN_W-1:0]   Run_Len,
   input  logic [STORE_DLY_W-1:0] Store_Delay,
   output logic                   Ctrl_Busy,
   output logic                   Done,
   output logic                   PE_Array_Busy,
   output logic                   In_Buf_Rd,
   output logic [BUF_AWIDTH-1:0]  In_Buf_Addr,
   input  logic [DWIDTH-1:0]      In_Buf_Data,
   output logic [DWIDTH-1:0]      PE_Load,
   input  logic [DWIDTH-1:0]      PE_Store,
   output logic                   Out_Buf_Wr,
   output logic [BUF_AWIDTH-1:0]  Out_Buf_Addr,
   output logic [DWIDTH-1:0]      Out_Buf_Data,
   output state_e                 Dbg_State
);

   state_e                 state_q, state_d;
   logic [RUN_LEN_W-1:0]   run_len_q, run_len_d;
   logic [STORE_DLY_W-1:0] store_dly_q, store_dly_d;
   logic [WIN_W-1:0]       win_end_q, win_end_d;
   logic [WIN_W-1:0]       cyc_q, cyc_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   arr_busy_q, arr_busy_d;
   logic                   rd_q, rd_d;
   logic                   rd_dly_q, rd_dly_d;
   logic [BUF_AWIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic [DWIDTH-1:0]      load_q, load_d;
   logic                   wr_q, wr_d;
   logic [BUF_AWIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [DWIDTH-1:0]      wr_data_q, wr_data_d;

   logic                   in_window;
   logic                   run_last;

   // cyc_q counts from RUN cycle 0 and keeps going through DRAIN so the store window
   // can extend past the end of RUN.
   assign in_window = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                      (cyc_q >= WIN_W'(store_dly_q)) && (cyc_q < win_end_q);
   assign run_last  = (cyc_q == (WIN_W'(run_len_q) - WIN_W'(1)));

   always_comb begin
      state_d     = state_q;
      run_len_d   = run_len_q;
      store_dly_d = store_dly_q;
      win_end_d   = win_end_q;
      cyc_d       = cyc_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               run_len_d   = Run_Len;
               store_dly_d = Store_Delay;
               win_end_d   = win_end(Run_Len, Store_Delay);
               cyc_d       = '0;
               state_d     = (Run_Len != '0) ? ST_RUN : ST_FIN;
            end
         end
         ST_RUN: begin
            cyc_d = cyc_q + WIN_W'(1);
            if (run_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            cyc_d = cyc_q + WIN_W'(1);
            // The last write strobe is on the bus this cycle once the window has closed.
            if (cyc_q >= win_end_q) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_FIN);
      arr_busy_d = (state_d == ST_RUN);
      rd_d       = (state_d == ST_RUN);
      rd_addr_d  = rd_addr_q;
      rd_dly_d   = rd_q;
      load_d     = rd_dly_q ? In_Buf_Data : load_q;
      wr_d       = in_window;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
         rd_addr_d = '0;
      end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
         rd_addr_d = rd_addr_q + BUF_AWIDTH'(1);
      end

      if (in_window) begin
         wr_addr_d = BUF_AWIDTH'(cyc_q - WIN_W'(store_dly_q));
         wr_data_d = PE_Store;
      end
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q     <= ST_IDLE;
         run_len_q   <= '0;
         store_dly_q <= '0;
         win_end_q   <= '0;
         cyc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         arr_busy_q  <= 1'b0;
         rd_q        <= 1'b0;
         rd_dly_q    <= 1'b0;
         rd_addr_q   <= '0;
         load_q      <= '0;
         wr_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         run_len_q   <= run_len_d;
         store_dly_q <= store_dly_d;
         win_end_q   <= win_end_d;
         cyc_q       <= cyc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         arr_busy_q  <= arr_busy_d;
         rd_q        <= rd_d;
         rd_dly_q    <= rd_dly_d;
         rd_addr_q   <= rd_addr_d;
         load_q      <= load_d;
         wr_q        <= wr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign Ctrl_Busy     = busy_q;
   assign Done          = done_q;
   assign PE_Array_Busy = arr_busy_q;
   assign In_Buf_Rd     = rd_q;
   assign In_Buf_Addr   = rd_addr_q;
   assign PE_Load       = load_q;
   assign Out_Buf_Wr    = wr_q;
   assign Out_Buf_Addr  = wr_addr_q;
   assign Out_Buf_Data  = wr_data_q;
   assign Dbg_State     = state_q;

endmodule

// File: tb/tb_scgra_io_ctrl.sv
// Directed bench for scgra_io_ctrl: a scoreboard queue holds expected output-buffer writes,
// a monitor pops them on every write strobe; per-cycle checks cover the read side and FSM.
module tb_scgra_io_ctrl;
   import scgra_io_pkg::*;

   localparam int DW = 32;
   localparam int AW = 2;
   localparam int NO_ABORT = 100000;

   logic   clk;
   logic   resetn;
   state_e dbg_state;

   scgra_io_ctrl_if #(.DWIDTH(DW), .BUF_AWIDTH(AW)) bus ();

   scgra_io_ctrl #(.DWIDTH(DW), .BUF_AWIDTH(AW)) dut (
      .Clk           (clk),
      .Resetn        (resetn),
      .Start         (bus.Start),
      .Run_Len       (bus.Run_Len),
      .Store_Delay   (bus.Store_Delay),
      .Ctrl_Busy     (bus.Ctrl_Busy),
      .Done          (bus.Done),
      .PE_Array_Busy (bus.PE_Array_Busy),
      .In_Buf_Rd     (bus.In_Buf_Rd),
      .In_Buf_Addr   (bus.In_Buf_Addr),
      .In_Buf_Data   (bus.In_Buf_Data),
      .PE_Load       (bus.PE_Load),
      .PE_Store      (bus.PE_Store),
      .Out_Buf_Wr    (bus.Out_Buf_Wr),
      .Out_Buf_Addr  (bus.Out_Buf_Addr),
      .Out_Buf_Data  (bus.Out_Buf_Data),
      .Dbg_State     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- input buffer model (one-cycle read latency) ----------------
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (bus.In_Buf_Rd) bus.In_Buf_Data <= mem[bus.In_Buf_Addr];
   end

   // ---------------- scoreboard ----------------
   logic [AW+DW-1:0] exp_q[$];
   int n_chk;
   int n_fail;
   int run_id;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] store_val(input int c);
      return {8'hC0, run_id[7:0], c[15:0]};
   endfunction

   always @(negedge clk) begin
      logic [AW+DW-1:0] exp_w;
      if (resetn && bus.Out_Buf_Wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_buf_write: got unexpected write addr %0h data %0h expected none (t=%0t)",
                     bus.Out_Buf_Addr, bus.Out_Buf_Data, $time);
         end else begin
            exp_w = exp_q.pop_front();
            chk("out_buf_write", {bus.Out_Buf_Addr, bus.Out_Buf_Data}, exp_w);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl_busy"},     bus.Ctrl_Busy,     0);
      chk({tag, "_done"},          bus.Done,          0);
      chk({tag, "_pe_array_busy"}, bus.PE_Array_Busy, 0);
      chk({tag, "_in_buf_rd"},     bus.In_Buf_Rd,     0);
      chk({tag, "_in_buf_addr"},   bus.In_Buf_Addr,   0);
      chk({tag, "_pe_load"},       bus.PE_Load,       0);
      chk({tag, "_out_buf_wr"},    bus.Out_Buf_Wr,    0);
      chk({tag, "_out_buf_addr"},  bus.Out_Buf_Addr,  0);
      chk({tag, "_out_buf_data"},  bus.Out_Buf_Data,  0);
   endtask

   // Cycle c = 0 is the first cycle after the edge that samples Start.
   task automatic run(input int rl, input int sd, input int poke_c, input int abort_c);
      int fin_c;
      run_id++;
      fin_c = (rl == 0) ? 0 : sd + rl + 1;
      for (int j = 0; j < rl; j++) begin
         if (sd + j + 1 < abort_c) exp_q.push_back({AW'(j), store_val(sd + j)});
      end

      @(negedge clk);
      bus.Start       = 1'b1;
      bus.Run_Len     = 16'(rl);
      bus.Store_Delay = 8'(sd);
      @(posedge clk);

      for (int c = 0; c <= fin_c + 1; c++) begin
         @(negedge clk);
         bus.Start    = (c == poke_c);
         if (c == poke_c) bus.Run_Len = 16'd9;
         bus.PE_Store = store_val(c);

         if (c == abort_c) begin
            resetn = 1'b0;
            #1;
            chk_zero("abort");
            @(negedge clk);
            resetn = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("post_abort_done", bus.Done, 0);
               chk("post_abort_busy", bus.Ctrl_Busy, 0);
            end
            chk("scoreboard_empty", exp_q.size(), 0);
            return;
         end

         chk("pe_array_busy", bus.PE_Array_Busy, (c < rl));
         chk("in_buf_rd",     bus.In_Buf_Rd,     (c < rl));
         if (c < rl) chk("in_buf_addr", bus.In_Buf_Addr, c % (1 << AW));
         if (rl > 0 && c >= 2) begin
            chk("pe_load", bus.PE_Load,
                32'h100 + ((((c - 2) < (rl - 1)) ? (c - 2) : (rl - 1)) % (1 << AW)));
         end
         chk("done",      bus.Done,      (c == fin_c));
         chk("ctrl_busy", bus.Ctrl_Busy, (c <= fin_c));
      end
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_chk           = 0;
      n_fail          = 0;
      run_id          = 0;
      resetn          = 1'b0;
      bus.Start       = 1'b0;
      bus.Run_Len     = '0;
      bus.Store_Delay = '0;
      bus.PE_Store    = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + i;

      repeat (2) @(negedge clk);
      chk_zero("reset");
      resetn = 1'b1;
      @(negedge clk);

      run(4, 3,   -1, NO_ABORT);   // basic streaming run
      run(0, 0,   -1, NO_ABORT);   // zero-length run goes straight to FIN
      run(3, 0,   -1, NO_ABORT);   // store window starts at RUN cycle 0
      run(6, 1,   -1, NO_ABORT);   // address wrap on a 2-bit buffer
      run(5, 2,    2, NO_ABORT);   // Start re-asserted mid-run is ignored
      run(2, 5,   -1, 4);          // reset while in DRAIN
      run(2, 0,   -1, NO_ABORT);   // restarts from address 0 after abort
      run(3, 200, -1, NO_ABORT);   // long store delay, window far past RUN

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
